// File: rtl/bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_arbiter_if : requester-side and external-bus signals of bus_arbiter  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface bus_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ-1:0]        i_req_rw;
  logic [N_REQ-1:0]        i_req_hold;
  logic [N_REQ*ADDR_W-1:0] i_req_addr;
  logic [N_REQ*DATA_W-1:0] i_req_wdata;
  logic [N_REQ-1:0]        o_gnt;
  logic [N_REQ-1:0]        o_done;
  logic [DATA_W-1:0]       o_rdata;
  logic                    o_err;
  logic                    o_rw;
  logic [ADDR_W-1:0]       o_addr;
  logic [DATA_W-1:0]       o_wdata;
  logic                    o_wdata_oe;
  logic [DATA_W-1:0]       i_rdata;
  logic                    i_ready;
  logic                    i_lock;
  logic                    o_busy;

  // The arbiter owns the master view; requesters and the external slave use slave.
  modport master (
    input  i_req, i_req_rw, i_req_hold, i_req_addr, i_req_wdata,
    input  i_rdata, i_ready, i_lock,
    output o_gnt, o_done, o_rdata, o_err, o_rw, o_addr, o_wdata, o_wdata_oe, o_busy
  );

  modport slave (
    output i_req, i_req_rw, i_req_hold, i_req_addr, i_req_wdata,
    output i_rdata, i_ready, i_lock,
    input  o_gnt, o_done, o_rdata, o_err, o_rw, o_addr, o_wdata, o_wdata_oe, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_arbiter : round-robin owner of the external addr/data bus with hold  |
// | Optional transfer timeout enabled by defining BUS_TIMEOUT_EN.             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module bus_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input wire logic      clk,
  input wire logic      n_rst,
  bus_arbiter_if.master bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt, win, win_nxt, win_inc;
  logic [PTR_W-1:0]  pick, scan, load_idx;
  logic              found, load, release_bus;
  logic [N_REQ-1:0]  gnt, gnt_nxt, done, done_nxt;
  logic [DATA_W-1:0] rdata, rdata_nxt, wdata, wdata_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              rw, rw_nxt, oe, oe_nxt;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
`endif

  // Round-robin scan starting at ptr; first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && bus.i_req[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  assign win_inc = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    win_nxt     = win;
    gnt_nxt     = gnt;
    done_nxt    = '0;
    rdata_nxt   = rdata;
    rw_nxt      = rw;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    oe_nxt      = oe;
    load        = 1'b0;
    load_idx    = win;
    release_bus = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_nxt     = cnt;
    err_nxt     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!bus.i_lock && found) begin
          load     = 1'b1;
          load_idx = pick;
        end
      end
      ST_XFER: begin
        if (bus.i_ready) begin
          done_nxt[win] = 1'b1;
          if (!rw) rdata_nxt = bus.i_rdata;
          // A lock seen in the completing cycle also blocks a pending hold.
          if (bus.i_req_hold[win] && bus.i_req[win] && !bus.i_lock) load = 1'b1;
          else release_bus = 1'b1;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_nxt[win] = 1'b1;
          err_nxt       = 1'b1;
          rdata_nxt     = '0;
          release_bus   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load) begin
      state_nxt          = ST_XFER;
      win_nxt            = load_idx;
      gnt_nxt            = '0;
      gnt_nxt[load_idx]  = 1'b1;
      rw_nxt             = bus.i_req_rw[load_idx];
      oe_nxt             = bus.i_req_rw[load_idx];
      addr_nxt           = bus.i_req_addr[load_idx*ADDR_W +: ADDR_W];
      wdata_nxt          = bus.i_req_wdata[load_idx*DATA_W +: DATA_W];
`ifdef BUS_TIMEOUT_EN
      cnt_nxt            = '0;
`endif
    end else if (release_bus) begin
      state_nxt = ST_IDLE;
      ptr_nxt   = win_inc;
      gnt_nxt   = '0;
      rw_nxt    = 1'b0;
      oe_nxt    = 1'b0;
      addr_nxt  = '0;
      wdata_nxt = '0;
`ifdef BUS_TIMEOUT_EN
      cnt_nxt   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
      done  <= '0;
      rdata <= '0;
      rw    <= 1'b0;
      oe    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt   <= '0;
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      rdata <= rdata_nxt;
      rw    <= rw_nxt;
      oe    <= oe_nxt;
      addr  <= addr_nxt;
      wdata <= wdata_nxt;
`ifdef BUS_TIMEOUT_EN
      cnt   <= cnt_nxt;
      err   <= err_nxt;
`endif
    end
  end

  assign bus.o_gnt      = gnt;
  assign bus.o_done     = done;
  assign bus.o_rdata    = rdata;
  assign bus.o_rw       = rw;
  assign bus.o_addr     = addr;
  assign bus.o_wdata    = wdata;
  assign bus.o_wdata_oe = oe;
  assign bus.o_busy     = (state == ST_XFER);
`ifdef BUS_TIMEOUT_EN
  assign bus.o_err      = err;
`else
  assign bus.o_err      = 1'b0;
`endif
endmodule
`default_nettype wire
